// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: two cores share one immediate-extension datapath.
// Each core gets a registered response slot and a saturating grant counter.
// Define IMM_EXT_ARB_RR_EN for round-robin tie-breaking.
// Without it, ties always go to core0.
module imm_ext_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [11:0]      imm12_0,
  input  logic [11:0]      imm12_1,
  input  logic [19:0]      imm20_0,
  input  logic [19:0]      imm20_1,
  input  logic [1:0]       ctrl0,
  input  logic [1:0]       ctrl1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [31:0]      rsp_imm0,
  output logic [31:0]      rsp_imm1,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  logic             elig0, elig1;
  logic             gnt0, gnt1;
  logic [11:0]      sel_imm12;
  logic [19:0]      sel_imm20;
  logic [1:0]       sel_ctrl;
  logic [31:0]      ext_imm;

  logic             rsp_valid0_q, rsp_valid0_d;
  logic             rsp_valid1_q, rsp_valid1_d;
  logic [31:0]      rsp_imm0_q, rsp_imm0_d;
  logic [31:0]      rsp_imm1_q, rsp_imm1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

`ifdef IMM_EXT_ARB_RR_EN
  // Set when core1 should win the next tie.
  logic             prio1_q, prio1_d;
`endif

  // Arbitration: a core may take a slot only if its response slot is free or draining.
  always_comb begin
    elig0 = req_valid0 & (~rsp_valid0_q | rsp_ready0);
    elig1 = req_valid1 & (~rsp_valid1_q | rsp_ready1);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (elig0 && elig1) begin
`ifdef IMM_EXT_ARB_RR_EN
      gnt0 = ~prio1_q;
      gnt1 = prio1_q;
`else
      gnt0 = 1'b1;
`endif
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
    // Reset also has to suppress handshakes combinationally.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign req_ready0 = gnt0;
  assign req_ready1 = gnt1;

  // Shared extension datapath, fed by the operands of the granted core.
  always_comb begin
    sel_imm12 = gnt1 ? imm12_1 : imm12_0;
    sel_imm20 = gnt1 ? imm20_1 : imm20_0;
    sel_ctrl  = gnt1 ? ctrl1   : ctrl0;
    case (sel_ctrl)
      2'b00:   ext_imm = {{20{sel_imm12[11]}}, sel_imm12};
      2'b01:   ext_imm = {{19{sel_imm12[11]}}, sel_imm12, 1'b0};
      2'b10:   ext_imm = {{12{sel_imm20[19]}}, sel_imm20};
      default: ext_imm = {{11{sel_imm20[19]}}, sel_imm20, 1'b0};
    endcase
  end

  // Response slots and grant counters.
  // A grant reloads the slot, even on the same edge that consumes the old result.
  always_comb begin
    rsp_valid0_d = rsp_valid0_q;
    rsp_valid1_d = rsp_valid1_q;
    rsp_imm0_d   = rsp_imm0_q;
    rsp_imm1_d   = rsp_imm1_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (gnt0) begin
      rsp_valid0_d = 1'b1;
      rsp_imm0_d   = ext_imm;
      if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + 1'b1;
    end else if (rsp_ready0) begin
      rsp_valid0_d = 1'b0;
    end
    if (gnt1) begin
      rsp_valid1_d = 1'b1;
      rsp_imm1_d   = ext_imm;
      if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + 1'b1;
    end else if (rsp_ready1) begin
      rsp_valid1_d = 1'b0;
    end
  end

  // State registers for the response slots and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_imm0_q   <= '0;
      rsp_imm1_q   <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_imm0_q   <= rsp_imm0_d;
      rsp_imm1_q   <= rsp_imm1_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

`ifdef IMM_EXT_ARB_RR_EN
  // Round-robin pointer: the core that was just served loses the next tie.
  always_comb begin
    prio1_d = prio1_q;
    if (gnt0)      prio1_d = 1'b1;
    else if (gnt1) prio1_d = 1'b0;
  end

  // Round-robin pointer register; reset gives core0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio1_q <= 1'b0;
    else        prio1_q <= prio1_d;
  end
`endif

  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_imm0   = rsp_imm0_q;
  assign rsp_imm1   = rsp_imm1_q;
  assign gnt_cnt0   = cnt0_q;
  assign gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter, built with CNT_W=2 so that counter saturation is reachable.
// A reference model pushes the expected immediates into per-core queues.
// A negedge monitor pops those queues and compares them against the DUT outputs.
module tb_imm_ext_arbiter;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid0, req_valid1;
  logic             req_ready0, req_ready1;
  logic [11:0]      imm12_0, imm12_1;
  logic [19:0]      imm20_0, imm20_1;
  logic [1:0]       ctrl0, ctrl1;
  logic             rsp_valid0, rsp_valid1;
  logic             rsp_ready0, rsp_ready1;
  logic [31:0]      rsp_imm0, rsp_imm1;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

  // Hand-computed extension result travelling with each core's operands.
  logic [31:0]      exp_imm0, exp_imm1;

  int n_checks = 0;
  int n_fail   = 0;

  imm_ext_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid0 (req_valid0),
    .req_valid1 (req_valid1),
    .req_ready0 (req_ready0),
    .req_ready1 (req_ready1),
    .imm12_0    (imm12_0),
    .imm12_1    (imm12_1),
    .imm20_0    (imm20_0),
    .imm20_1    (imm20_1),
    .ctrl0      (ctrl0),
    .ctrl1      (ctrl1),
    .rsp_valid0 (rsp_valid0),
    .rsp_valid1 (rsp_valid1),
    .rsp_ready0 (rsp_ready0),
    .rsp_ready1 (rsp_ready1),
    .rsp_imm0   (rsp_imm0),
    .rsp_imm1   (rsp_imm1),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic             m_valid0 = 1'b0, m_valid1 = 1'b0;
  logic [CNT_W-1:0] m_cnt0 = '0, m_cnt1 = '0;
  logic [31:0]      m_last0 = '0, m_last1 = '0;
  logic [31:0]      q0[$], q1[$];
`ifdef IMM_EXT_ARB_RR_EN
  logic             m_prio1 = 1'b0;
`endif

  // Expected grant vector {core1, core0} for the current inputs.
  function automatic logic [1:0] mgrant();
    logic e0, e1;
    e0 = req_valid0 && (!m_valid0 || rsp_ready0);
    e1 = req_valid1 && (!m_valid1 || rsp_ready1);
    if (rst_n !== 1'b1) return 2'b00;
    if (e0 && e1) begin
`ifdef IMM_EXT_ARB_RR_EN
      return m_prio1 ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return {e1, e0};
  endfunction

  // Model update: on each grant, push the expected result into that core's queue.
  always @(posedge clk or negedge rst_n) begin : p_model
    logic [1:0] g;
    if (!rst_n) begin
      m_valid0 = 1'b0;
      m_valid1 = 1'b0;
      m_cnt0   = '0;
      m_cnt1   = '0;
      m_last0  = '0;
      m_last1  = '0;
      q0.delete();
      q1.delete();
`ifdef IMM_EXT_ARB_RR_EN
      m_prio1  = 1'b0;
`endif
    end else begin
      g = mgrant();
      if (g[0]) begin
        q0.push_back(exp_imm0);
        m_valid0 = 1'b1;
        if (m_cnt0 != {CNT_W{1'b1}}) m_cnt0 = m_cnt0 + 1'b1;
      end else if (rsp_ready0) begin
        m_valid0 = 1'b0;
      end
      if (g[1]) begin
        q1.push_back(exp_imm1);
        m_valid1 = 1'b1;
        if (m_cnt1 != {CNT_W{1'b1}}) m_cnt1 = m_cnt1 + 1'b1;
      end else if (rsp_ready1) begin
        m_valid1 = 1'b0;
      end
`ifdef IMM_EXT_ARB_RR_EN
      if (g[0])      m_prio1 = 1'b1;
      else if (g[1]) m_prio1 = 1'b0;
`endif
    end
  end

  // Monitor: compare handshakes, counters and any result the DUT presents.
  always @(negedge clk) begin : p_mon
    logic [1:0] g;
    g = mgrant();
    chk("req_ready0", {31'b0, req_ready0}, {31'b0, g[0]});
    chk("req_ready1", {31'b0, req_ready1}, {31'b0, g[1]});
    chk("rsp_valid0", {31'b0, rsp_valid0}, {31'b0, m_valid0});
    chk("rsp_valid1", {31'b0, rsp_valid1}, {31'b0, m_valid1});
    chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
    chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
    if (rsp_valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_imm0 unexpected: got %h expected no result at %0t", rsp_imm0, $time);
      end else begin
        chk("rsp_imm0", rsp_imm0, q0[0]);
        if (rsp_ready0) m_last0 = q0.pop_front();
      end
    end else begin
      chk("rsp_imm0 hold", rsp_imm0, m_last0);
    end
    if (rsp_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_imm1 unexpected: got %h expected no result at %0t", rsp_imm1, $time);
      end else begin
        chk("rsp_imm1", rsp_imm1, q1[0]);
        if (rsp_ready1) m_last1 = q1.pop_front();
      end
    end else begin
      chk("rsp_imm1 hold", rsp_imm1, m_last1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [11:0] a, input logic [19:0] b,
                      input logic [1:0] c, input logic [31:0] e);
    req_valid0 = v;
    imm12_0    = a;
    imm20_0    = b;
    ctrl0      = c;
    exp_imm0   = e;
  endtask

  task automatic set1(input logic v, input logic [11:0] a, input logic [19:0] b,
                      input logic [1:0] c, input logic [31:0] e);
    req_valid1 = v;
    imm12_1    = a;
    imm20_1    = b;
    ctrl1      = c;
    exp_imm1   = e;
  endtask

  task automatic rdy(input logic r0, input logic r1);
    rsp_ready0 = r0;
    rsp_ready1 = r1;
  endtask

  task automatic idle();
    set0(1'b0, 12'h0, 20'h0, 2'b00, 32'h0);
    set1(1'b0, 12'h0, 20'h0, 2'b00, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int cnt_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset state: requests are present while reset is held.
    rst_n = 1'b0;
    rdy(1'b1, 1'b1);
    set0(1'b1, 12'h001, 20'h0, 2'b00, 32'h1);
    set1(1'b1, 12'h002, 20'h0, 2'b00, 32'h2);
    tick();
    chk("reset req_ready0", {31'b0, req_ready0}, 32'h0);
    chk("reset req_ready1", {31'b0, req_ready1}, 32'h0);
    chk("reset rsp_valid0", {31'b0, rsp_valid0}, 32'h0);
    chk("reset rsp_imm1", rsp_imm1, 32'h0);
    chk("reset gnt_cnt0", 32'(gnt_cnt0), 32'h0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    // Core0 alone, 12-bit sign extension.
    set0(1'b1, 12'h801, 20'h0, 2'b00, 32'hFFFFF801);
    tick();
    set0(1'b0, 12'h0, 20'h0, 2'b00, 32'h0);
    chk("t1 gnt_cnt0", 32'(gnt_cnt0), 32'h1);
    chk("t1 rsp_imm0", rsp_imm0, 32'hFFFFF801);
    tick();
    tick();

    // Core1 alone, all four modes, back to back.
    set1(1'b1, 12'h7FF, 20'h0, 2'b01, 32'h00000FFE);
    tick();
    set1(1'b1, 12'h0, 20'h80001, 2'b10, 32'hFFF80001);
    tick();
    set1(1'b1, 12'h0, 20'h80001, 2'b11, 32'hFFF00002);
    tick();
    set1(1'b1, 12'h800, 20'h0, 2'b01, 32'hFFFFF000);
    tick();
    set1(1'b1, 12'h0, 20'h7FFFF, 2'b10, 32'h0007FFFF);
    tick();
    idle();
    tick();
    tick();

    // Both cores request continuously.
    do_reset();
    set0(1'b1, 12'h123, 20'h0, 2'b00, 32'h00000123);
    set1(1'b1, 12'h0, 20'hFFFFF, 2'b11, 32'hFFFFFFFE);
    repeat (6) tick();
    chk("t3 gnt_cnt0", 32'(gnt_cnt0), 32'h3);
`ifdef IMM_EXT_ARB_RR_EN
    chk("t3 gnt_cnt1", 32'(gnt_cnt1), 32'h3);
`else
    chk("t3 gnt_cnt1", 32'(gnt_cnt1), 32'h0);
`endif
    idle();
    tick();
    tick();

    // Core0 result stalled: core0 is ineligible and core1 takes the datapath.
    do_reset();
    rdy(1'b0, 1'b1);
    set0(1'b1, 12'h0AB, 20'h0, 2'b00, 32'h000000AB);
    tick();
    set0(1'b1, 12'h0, 20'h12345, 2'b10, 32'h00012345);
    set1(1'b1, 12'hFFF, 20'h0, 2'b00, 32'hFFFFFFFF);
    repeat (3) tick();
    chk("t4 rsp_imm0 stalled", rsp_imm0, 32'h000000AB);
    chk("t4 gnt_cnt1", 32'(gnt_cnt1), 32'h3);
    rdy(1'b1, 1'b1);
    tick();
    chk("t4 rsp_imm0 reload", rsp_imm0, 32'h00012345);
    set0(1'b0, 12'h0, 20'h0, 2'b00, 32'h0);
    tick();
    idle();
    tick();
    tick();

    // Reset asserted while a result is pending.
    do_reset();
    rdy(1'b0, 1'b1);
    set0(1'b1, 12'h555, 20'h0, 2'b00, 32'h00000555);
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5 rsp_valid0", {31'b0, rsp_valid0}, 32'h0);
    chk("t5 rsp_imm0", rsp_imm0, 32'h0);
    chk("t5 gnt_cnt0", 32'(gnt_cnt0), 32'h0);
    chk("t5 req_ready0", {31'b0, req_ready0}, 32'h0);
    tick();
    tick();
    idle();
    rdy(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (3) tick();
    set0(1'b1, 12'h001, 20'h0, 2'b00, 32'h00000001);
    set1(1'b1, 12'h002, 20'h0, 2'b00, 32'h00000002);
    #1;
    chk("t5 first grant core0", {30'b0, req_ready1, req_ready0}, 32'h1);
    tick();
    set0(1'b0, 12'h0, 20'h0, 2'b00, 32'h0);
    tick();
    idle();
    tick();
    tick();

    // Counter saturation at CNT_W=2.
    do_reset();
    rdy(1'b1, 1'b1);
    set0(1'b1, 12'hFFF, 20'h0, 2'b01, 32'hFFFFFFFE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6 gnt_cnt0 sat", 32'(gnt_cnt0), cnt_exp[i]);
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
